pipe_addsub: RTL and testbench
==============================

PIPE_ADDSUB -- requirements
Module: pipe_addsub

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits.
REQ-002 SHALL have parameter SEG, default 4, bits per pipeline segment; WIDTH % SEG == 0; NSEG = WIDTH/SEG.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operand beat present.
REQ-006 SHALL have port in_ready  output  1  beat accepted when in_valid & in_ready.
REQ-007 SHALL have port a  input  WIDTH  operand A.
REQ-008 SHALL have port b  input  WIDTH  operand B.
REQ-009 SHALL have port cin  input  1  carry-in.
REQ-010 SHALL have port sub  input  1  1 = invert B (subtract).
REQ-011 SHALL have port sat  input  1  1 = signed saturation of result.
REQ-012 SHALL have port out_valid  output  1  result beat present.
REQ-013 SHALL have port out_ready  input  1  downstream accepts result.
REQ-014 SHALL have port f  output  WIDTH  result.
REQ-015 SHALL have port cout  output  1  carry out of MSB (unsaturated).
REQ-016 SHALL have port ovf  output  1  signed overflow (carry into MSB XOR cout).
REQ-017 SHALL have port zero  output  1  f == 0 (after saturation).
REQ-018 SHALL have port neg  output  1  f[WIDTH-1] (after saturation).

Function
REQ-019 SHALL compute raw = a + (b XOR {WIDTH{sub}}) + cin, (WIDTH+1)-bit, cout = raw[WIDTH]; a-b requires sub=1, cin=1.
REQ-020 SHALL split the carry chain into NSEG registered stages; stage k adds segment k using carry registered from stage k-1; higher segments of a, b, sub, sat carried forward in skew registers.
REQ-021 SHALL present result NSEG cycles after acceptance when out_ready held high (NSEG=1 gives 1-cycle latency).
REQ-022 SHALL sustain one accepted beat per cycle when unstalled.
REQ-023 SHALL advance all stages together iff advance = ~out_valid | out_ready; in_ready = advance (combinational, no in_valid dependency).
REQ-024 SHALL hold every stage register, including valid bits, when advance = 0; f/flags stable while out_valid & ~out_ready.
REQ-025 SHALL propagate a per-stage valid bit; bubble (in_valid=0 on advance) SHALL yield out_valid=0 in its slot, no result change required.
REQ-026 SHALL, when sat=1 and ovf=1, force f to 0111..1 if a[MSB]=0 else 1000..0; cout and ovf report unsaturated values.
REQ-027 SHALL compute zero and neg from final f in the last stage, registered with f.
REQ-028 SHALL wrap modulo 2^WIDTH when sat=0 (e.g. FFFF+0001 = 0000, cout=1).
REQ-029 SHALL treat per-beat sub, cin, sat independently; adjacent beats of different modes SHALL not interfere.

Reset
REQ-030 SHALL, on rst=1, asynchronously clear all valid bits, f, cout, ovf, zero, neg to 0; in_ready = 1 during/after reset.
REQ-031 SHALL discard all in-flight beats on reset mid-operation; first result after release comes only from beats accepted after release.
REQ-032 SHALL accept a beat on the first rising edge with rst=0.

Verification (WIDTH=16, SEG=4)
REQ-033 SHALL pass: a=1234h,b=0FFFh,sub=0,cin=0, out_ready=1 -> after 4 cycles f=2233h, cout=0, ovf=0, zero=0, neg=0.
REQ-034 SHALL pass: a=0005h,b=0005h,sub=1,cin=1 -> f=0000h, cout=1, zero=1; a=7FFFh,b=0001h,sub=0,cin=0,sat=1 -> f=7FFFh, ovf=1; same with sat=0 -> f=8000h, neg=1.
REQ-035 SHALL pass: a=8000h,b=0001h,sub=1,cin=1,sat=1 -> f=8000h, ovf=1, neg=1, cout=1.
REQ-036 SHALL pass: 8 back-to-back beats, out_ready toggling pseudo-randomly -> all 8 results in order, none dropped/duplicated, outputs stable while stalled, in_ready low exactly when out_valid & ~out_ready.
REQ-037 SHALL pass: 3 beats in flight, rst pulsed 1 for a partial cycle -> out_valid=0 immediately; no stale result after release.
REQ-038 SHALL pass: random a,b,sub,cin,sat vs reference model for WIDTH=16/SEG=4, WIDTH=32/SEG=8, WIDTH=8/SEG=8.

Source files
------------

// File: rtl/pipe_addsub.sv
// pipe_addsub: adder/subtractor whose carry chain is cut into SEG-bit segments,
// one segment resolved per registered stage, with optional signed saturation.
module pipe_addsub #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);
  localparam int NSEG = WIDTH / SEG;

  // Handshake: a beat transfers on a rising edge where valid & ready are both high.
  // The whole pipe moves together whenever the output slot is empty or being drained,
  // so in_ready depends only on the output side and never on in_valid.
  logic advance;
  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  for (genvar k = 0; k < NSEG; k++) begin : stg
    localparam int LO = k * SEG;     // bits already summed before this stage
    localparam int UP = WIDTH - LO;  // operand bits still to be summed, incl. this segment

    logic              v_in, c_in, sub_in, sat_in;
    logic [UP-1:0]     a_in, b_in;
    logic [SEG-1:0]    b_seg;
    logic [SEG:0]      seg_sum;
    logic [LO+SEG-1:0] p_all;

    assign b_seg   = b_in[SEG-1:0] ^ {SEG{sub_in}};
    assign seg_sum = {1'b0, a_in[SEG-1:0]} + {1'b0, b_seg} + {{SEG{1'b0}}, c_in};

    if (k == 0) begin : g_src
      assign v_in   = in_valid;
      assign c_in   = cin;
      assign sub_in = sub;
      assign sat_in = sat;
      assign a_in   = a;
      assign b_in   = b;
      assign p_all  = seg_sum[SEG-1:0];
    end else begin : g_src
      assign v_in   = stg[k-1].g_reg.v_q;
      assign c_in   = stg[k-1].g_reg.c_q;
      assign sub_in = stg[k-1].g_reg.sub_q;
      assign sat_in = stg[k-1].g_reg.sat_q;
      assign a_in   = stg[k-1].g_reg.a_q;
      assign b_in   = stg[k-1].g_reg.b_q;
      assign p_all  = {seg_sum[SEG-1:0], stg[k-1].g_reg.p_q};
    end

    if (k < NSEG - 1) begin : g_reg
      logic              v_q, c_q, sub_q, sat_q;
      logic [UP-SEG-1:0] a_q, b_q;  // skewed operand bits not yet summed
      logic [LO+SEG-1:0] p_q;       // low result bits finished so far

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          v_q   <= 1'b0;
          c_q   <= 1'b0;
          sub_q <= 1'b0;
          sat_q <= 1'b0;
          a_q   <= '0;
          b_q   <= '0;
          p_q   <= '0;
        end else if (advance) begin
          v_q   <= v_in;
          c_q   <= seg_sum[SEG];
          sub_q <= sub_in;
          sat_q <= sat_in;
          a_q   <= a_in[UP-1:SEG];
          b_q   <= b_in[UP-1:SEG];
          p_q   <= p_all;
        end
      end
    end else begin : g_last
      logic             c_msb, ovf_raw;
      logic [WIDTH-1:0] f_sat;

      // Overflow is the carry into the MSB disagreeing with the carry out of it.
      always_comb begin
        c_msb   = a_in[SEG-1] ^ b_seg[SEG-1] ^ seg_sum[SEG-1];
        ovf_raw = c_msb ^ seg_sum[SEG];
        f_sat   = p_all;
        if (sat_in && ovf_raw) begin
          f_sat = a_in[SEG-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          out_valid <= 1'b0;
          f         <= '0;
          cout      <= 1'b0;
          ovf       <= 1'b0;
          zero      <= 1'b0;
          neg       <= 1'b0;
        end else if (advance) begin
          out_valid <= v_in;
          f         <= f_sat;
          cout      <= seg_sum[SEG];
          ovf       <= ovf_raw;
          zero      <= (f_sat == '0);
          neg       <= f_sat[WIDTH-1];
        end
      end
    end
  end
endmodule

// File: tb/tb_pipe_addsub.sv
// Bench for pipe_addsub: 16/4 main instance with directed, stall and reset scenarios,
// plus 32/8 and 8/8 instances under random traffic, all scored against a plain-arithmetic model.
`timescale 1ns/1ps
module tb_pipe_addsub;
  localparam int WIDTH = 16;
  localparam int SEG   = 4;
  localparam int NSEG  = WIDTH / SEG;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic aux_rst = 1'b1;
  always #5 clk = ~clk;

  logic             in_valid, in_ready, cin, sub, sat;
  logic [WIDTH-1:0] a, b, f;
  logic             out_valid, cout, ovf, zero, neg;
  logic             out_ready = 1'b1;
  int               rdy_mode = 0;  // 0: always ready, 1: random, 2: never ready

  int n_tests = 0;
  int n_fail  = 0;
  logic [67:0] exp_q[$];
  logic [67:0] held;
  logic        stalled = 1'b0;

  pipe_addsub #(.WIDTH(WIDTH), .SEG(SEG)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .sat(sat),
    .out_valid(out_valid), .out_ready(out_ready),
    .f(f), .cout(cout), .ovf(ovf), .zero(zero), .neg(neg)
  );

  // Reference: {cout, ovf, zero, neg, f} from the arithmetic rules, any width up to 32.
  function automatic logic [67:0] ref_model(input int w, input logic [63:0] ra, input logic [63:0] rb,
                                            input logic rc, input logic rs, input logic rt);
    logic [63:0] mask, bb, raw, res;
    logic        co, ov, sa, sb;
    mask = (64'd1 << w) - 64'd1;
    bb   = rs ? (~rb & mask) : (rb & mask);
    raw  = (ra & mask) + bb + {63'd0, rc};
    co   = raw[w];
    res  = raw & mask;
    sa   = ra[w-1];
    sb   = bb[w-1];
    ov   = (sa == sb) && (res[w-1] != sa);
    if (rt && ov) res = sa ? (64'd1 << (w - 1)) : (mask >> 1);
    return {co, ov, (res == 64'd0), res[w-1], res};
  endfunction

  task automatic check(input string nm, input logic [67:0] act, input logic [67:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] pick();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h7FFF;
      3: return 16'h8000;
      4: return 16'h0001;
      default: return WIDTH'($urandom());
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                      input logic tc, input logic ts, input logic tt, output int waits);
    logic acc;
    in_valid = 1'b1; a = ta; b = tb_v; cin = tc; sub = ts; sat = tt;
    waits = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      waits++;
    end while (!acc && waits < 200);
    if (acc) exp_q.push_back(ref_model(WIDTH, 64'(ta), 64'(tb_v), tc, ts, tt));
    else check("accept_timeout", 68'(acc), 68'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain", 68'(exp_q.size()), 68'd0);
  endtask

  task automatic wait_out(output int cyc);
    cyc = 1;
    while (!out_valid && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  always begin
    @(posedge clk); #1;
    case (rdy_mode)
      1:       out_ready = 1'($urandom_range(0, 1));
      2:       out_ready = 1'b0;
      default: out_ready = 1'b1;
    endcase
  end

  // ---------------- scoreboard monitor ----------------
  always begin
    logic [67:0] cur;
    @(negedge clk);
    cur = {cout, ovf, zero, neg, 48'd0, f};
    if (rst) begin
      stalled = 1'b0;
    end else begin
      check("in_ready", 68'(in_ready), 68'(!(out_valid && !out_ready)));
      if (stalled) begin
        check("stall_valid", 68'(out_valid), 68'd1);
        check("stall_hold", cur, held);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("spurious_out", 68'(out_valid), 68'd0);
        else check("result", cur, exp_q.pop_front());
      end
      stalled = out_valid && !out_ready;
      held    = cur;
    end
  end

  // ---------------- wider / single-segment instances ----------------
  for (genvar g = 0; g < 2; g++) begin : aux
    localparam int AW = (g == 0) ? 32 : 8;
    localparam int AS = 8;
    logic          x_in_valid, x_in_ready, x_cin, x_sub, x_sat;
    logic [AW-1:0] x_a, x_b, x_f;
    logic          x_out_valid, x_cout, x_ovf, x_zero, x_neg;
    logic          x_out_ready = 1'b1;
    logic          done = 1'b0;
    logic [67:0]   q[$];

    pipe_addsub #(.WIDTH(AW), .SEG(AS)) dut_x (
      .clk(clk), .rst(aux_rst), .in_valid(x_in_valid), .in_ready(x_in_ready),
      .a(x_a), .b(x_b), .cin(x_cin), .sub(x_sub), .sat(x_sat),
      .out_valid(x_out_valid), .out_ready(x_out_ready),
      .f(x_f), .cout(x_cout), .ovf(x_ovf), .zero(x_zero), .neg(x_neg)
    );

    always begin
      @(posedge clk); #1;
      x_out_ready = 1'($urandom_range(0, 3) != 0);
    end

    always begin
      @(negedge clk);
      if (!aux_rst && x_out_valid && x_out_ready) begin
        if (q.size() == 0) check("aux_spurious", 68'(x_out_valid), 68'd0);
        else check((g == 0) ? "aux32_result" : "aux8_result",
                   {x_cout, x_ovf, x_zero, x_neg, 64'(x_f)}, q.pop_front());
      end
    end

    initial begin
      int t;
      x_in_valid = 1'b0; x_a = '0; x_b = '0; x_cin = 1'b0; x_sub = 1'b0; x_sat = 1'b0;
      wait (!aux_rst);
      for (int i = 0; i < 150; i++) begin
        x_a   = ($urandom_range(0, 3) == 0) ? {1'b0, {(AW-1){1'b1}}} : AW'($urandom());
        x_b   = AW'($urandom());
        x_cin = 1'($urandom_range(0, 1));
        x_sub = 1'($urandom_range(0, 1));
        x_sat = 1'($urandom_range(0, 1));
        x_in_valid = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        if (x_in_valid && x_in_ready) q.push_back(ref_model(AW, 64'(x_a), 64'(x_b), x_cin, x_sub, x_sat));
        @(posedge clk); #1;
      end
      x_in_valid = 1'b0;
      t = 0;
      while (q.size() != 0 && t < 500) begin
        @(posedge clk); #1;
        t++;
      end
      check("aux_drain", 68'(q.size()), 68'd0);
      done = 1'b1;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int w, cyc;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; sat = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 68'(out_valid), 68'd0);
    check("rst_flags_f", {cout, ovf, zero, neg, 48'd0, f}, 68'd0);
    check("rst_in_ready", 68'(in_ready), 68'd1);
    rst = 1'b0;
    aux_rst = 1'b0;

    // Directed beats; the first is accepted on the first edge after release.
    send(16'h1234, 16'h0FFF, 1'b0, 1'b0, 1'b0, w);
    check("first_accept_wait", 68'(w), 68'd1);
    wait_out(cyc);
    check("latency", 68'(cyc), 68'(NSEG));
    send(16'h0005, 16'h0005, 1'b1, 1'b1, 1'b0, w);
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, w);
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, w);
    send(16'h8000, 16'h0001, 1'b1, 1'b1, 1'b1, w);
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, w);
    send(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b1, w);
    drain();

    // Eight back-to-back beats under random back-pressure.
    rdy_mode = 1;
    for (int i = 0; i < 8; i++)
      send(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), w);
    drain();

    // Long random run with bubbles and mixed modes.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) idle();
      send(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), w);
    end
    drain();

    // Three beats in flight, output stalled, then a short reset pulse.
    rdy_mode = 2;
    repeat (2) idle();
    for (int i = 0; i < 3; i++) send(pick(), pick(), 1'b0, 1'b0, 1'b0, w);
    wait_out(cyc);
    check("stalled_valid_before_rst", 68'(out_valid), 68'd1);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 68'(out_valid), 68'd0);
    check("mid_rst_in_ready", 68'(in_ready), 68'd1);
    exp_q.delete();
    stalled = 1'b0;
    #1 rst = 1'b0;
    rdy_mode = 0;
    repeat (NSEG + 3) begin
      idle();
      check("no_stale_after_rst", 68'(out_valid), 68'd0);
    end
    send(16'hABCD, 16'h1111, 1'b1, 1'b1, 1'b0, w);
    drain();

    for (int t = 0; t < 5000 && !(aux[0].done && aux[1].done); t++) @(posedge clk);
    check("aux_finished", {66'd0, aux[1].done, aux[0].done}, 68'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
